// File: rtl/cpu_pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pipe_ctrl_pkg
// Shared definitions for the 5-stage pipeline control unit: FSM state
// encodings, default parameter values and a sizing helper for the MDU
// latency counter.
// ---------------------------------------------------------------------------
package cpu_pipe_ctrl_pkg;

  // FSM encodings; the datapath debug view relies on these exact values
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam int DEF_REG_AW  = 5;
  localparam int DEF_MDU_LAT = 4;
  localparam int DEF_CNT_W   = 32;

  // Width needed to hold the MDU countdown value (MDU_LAT-1 down to 0)
  function automatic int mdu_cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/cpu_pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_pipe_ctrl_if
// Bundle between the pipeline datapath and the pipeline control unit.
//   Hazard inputs : id_rs1_addr/id_rs2_addr/id_rs1_used/id_rs2_used,
//                   ex_rd_addr/ex_mem_read, ex_redirect, ex_mdu_start,
//                   imem_ready, mem_access, dmem_ready
//   Control out   : pc_stall, pc_redirect, {if_id,id_ex,ex_mem}_stall,
//                   {if_id,id_ex,ex_mem,mem_wb}_flush, mdu_busy
//   Perf out      : perf_stall_cnt, perf_flush_cnt
// Modports: master = datapath side, slave = control unit side.
// ---------------------------------------------------------------------------
interface cpu_pipe_ctrl_if
  import cpu_pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = DEF_CNT_W
);

  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_mem_read;
  logic              ex_redirect;
  logic              ex_mdu_start;
  logic              imem_ready;
  logic              mem_access;
  logic              dmem_ready;

  logic              pc_stall;
  logic              pc_redirect;
  logic              if_id_stall;
  logic              if_id_flush;
  logic              id_ex_stall;
  logic              id_ex_flush;
  logic              ex_mem_stall;
  logic              ex_mem_flush;
  logic              mem_wb_flush;
  logic              mdu_busy;
  logic [CNT_W-1:0]  perf_stall_cnt;
  logic [CNT_W-1:0]  perf_flush_cnt;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_rd_addr, ex_mem_read, ex_redirect, ex_mdu_start,
           imem_ready, mem_access, dmem_ready,
    input  pc_stall, pc_redirect, if_id_stall, if_id_flush,
           id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush,
           mem_wb_flush, mdu_busy, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_rd_addr, ex_mem_read, ex_redirect, ex_mdu_start,
           imem_ready, mem_access, dmem_ready,
    output pc_stall, pc_redirect, if_id_stall, if_id_flush,
           id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush,
           mem_wb_flush, mdu_busy, perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/cpu_pipe_ctrl_hazard_det.sv
// ---------------------------------------------------------------------------
// cpu_hazard_det
// Combinational load-use comparator. Flags when the instruction in ID reads
// a register that the load currently in EX will write. x0 never hazards.
//   rs1_addr_i/rs2_addr_i : ID source registers
//   rs1_used_i/rs2_used_i : ID instruction actually reads that source
//   rd_addr_i             : EX destination register
//   mem_read_i            : EX instruction is a load
//   load_use_o            : one-bubble stall required
// ---------------------------------------------------------------------------
module cpu_hazard_det
  import cpu_pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              mem_read_i,
  output logic              load_use_o
);

  // Only loads need a bubble; every other RAW case is covered by forwarding
  always_comb begin
    load_use_o = mem_read_i && (rd_addr_i != '0) &&
                 ((rs1_used_i && (rs1_addr_i == rd_addr_i)) ||
                  (rs2_used_i && (rs2_addr_i == rd_addr_i)));
  end

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_pipe_ctrl
// Pipeline control unit for the 5-stage core. Produces per-stage stall and
// flush, PC redirect, and MDU busy from load-use hazards, EX branch/jump
// resolution, the multi-cycle MUL/DIV unit and imem/dmem wait handshakes.
//   clk  : core clock
//   rst  : synchronous reset, active-high (forces all flushes)
//   ctrl : cpu_pipe_ctrl_if.slave bundle (hazard inputs, control outputs,
//          perf counters)
// Optional feature macro: CPU_PIPE_PERF_EN -- when defined, saturating
// counters of stalled cycles and redirect cycles; otherwise both tie to 0.
// ---------------------------------------------------------------------------
module cpu_pipe_ctrl
  import cpu_pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = DEF_REG_AW,
  parameter int MDU_LAT = DEF_MDU_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  cpu_pipe_ctrl_if.slave ctrl
);

  localparam int MCW = mdu_cnt_width(MDU_LAT);
  localparam logic [MCW-1:0] MDU_LOAD = MCW'(MDU_LAT - 1);
  localparam logic [MCW-1:0] MDU_ONE  = MCW'(1);

  state_e         state_q, state_d;
  state_e         ret_q, ret_d;
  state_e         eff_state;
  logic [MCW-1:0] mdu_cnt_q, mdu_cnt_d;

  logic dmem_stall;
  logic load_use;
  logic mdu_launch;
  logic mdu_active;

  logic pc_stall, pc_redirect;
  logic if_id_stall, if_id_flush;
  logic id_ex_stall, id_ex_flush;
  logic ex_mem_stall, ex_mem_flush;
  logic mem_wb_flush, mdu_busy;

  cpu_hazard_det #(.REG_AW(REG_AW)) u_hazard_det (
    .rs1_addr_i (ctrl.id_rs1_addr),
    .rs2_addr_i (ctrl.id_rs2_addr),
    .rs1_used_i (ctrl.id_rs1_used),
    .rs2_used_i (ctrl.id_rs2_used),
    .rd_addr_i  (ctrl.ex_rd_addr),
    .mem_read_i (ctrl.ex_mem_read),
    .load_use_o (load_use)
  );

  // While waiting on dmem the FSM remembers what it was doing; once the
  // access completes the pipeline behaves as if it were already back in
  // that state, so an MDU op in flight keeps the front end held.
  always_comb begin
    dmem_stall = ctrl.mem_access && !ctrl.dmem_ready;
    eff_state  = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
    mdu_launch = (eff_state == ST_RUN) && ctrl.ex_mdu_start && !dmem_stall;
    mdu_active = (eff_state == ST_MDU_WAIT) || mdu_launch;
  end

  // Next-state logic. The MDU countdown only moves in MDU_WAIT with no dmem
  // stall, so it is frozen both in MEM_WAIT and on the cycle a stall begins.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    mdu_cnt_d = mdu_cnt_q;
    if (dmem_stall) begin
      if (state_q != ST_MEM_WAIT) begin
        ret_d   = state_q;
        state_d = ST_MEM_WAIT;
      end
    end else begin
      case (eff_state)
        ST_RUN: begin
          state_d = ST_RUN;
          if (mdu_launch) begin
            state_d   = ST_MDU_WAIT;
            mdu_cnt_d = MDU_LOAD;
          end
        end
        ST_MDU_WAIT: begin
          state_d = ST_MDU_WAIT;
          if (state_q == ST_MDU_WAIT) begin
            if (mdu_cnt_q <= MDU_ONE) begin
              state_d   = ST_RUN;
              mdu_cnt_d = '0;
            end else begin
              mdu_cnt_d = mdu_cnt_q - MDU_ONE;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // FSM and MDU counter registers; reset abandons any MDU or dmem wait
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      ret_q     <= ST_RUN;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  // Stall/flush priority: dmem wait, MDU busy, EX redirect, load-use, imem.
  // A redirect held in EX during a dmem wait is taken on the release cycle.
  always_comb begin
    pc_stall     = 1'b0;
    pc_redirect  = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    mdu_busy     = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      mdu_busy = mdu_active;
      if (dmem_stall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (mdu_active) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (ctrl.ex_redirect) begin
        pc_redirect  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (!ctrl.imem_ready) begin
        pc_stall     = 1'b1;
        if_id_flush  = 1'b1;
      end
    end
  end

  assign ctrl.pc_stall     = pc_stall;
  assign ctrl.pc_redirect  = pc_redirect;
  assign ctrl.if_id_stall  = if_id_stall;
  assign ctrl.if_id_flush  = if_id_flush;
  assign ctrl.id_ex_stall  = id_ex_stall;
  assign ctrl.id_ex_flush  = id_ex_flush;
  assign ctrl.ex_mem_stall = ex_mem_stall;
  assign ctrl.ex_mem_flush = ex_mem_flush;
  assign ctrl.mem_wb_flush = mem_wb_flush;
  assign ctrl.mdu_busy     = mdu_busy;

`ifdef CPU_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: they stick at all-ones instead of wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (pc_redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ctrl.perf_stall_cnt = stall_cnt_q;
  assign ctrl.perf_flush_cnt = flush_cnt_q;
`else
  assign ctrl.perf_stall_cnt = '0;
  assign ctrl.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_pipe_ctrl
// Directed bench for cpu_pipe_ctrl. Each step drives one cycle of inputs and
// pushes the expected control vector (plus expected perf counts) onto a
// scoreboard; the entry is popped and compared mid-cycle on the falling edge.
// A narrow counter width is used so perf counter saturation is reachable.
// ---------------------------------------------------------------------------
module tb_cpu_pipe_ctrl;
  import cpu_pipe_ctrl_pkg::*;

  localparam int REG_AW  = 5;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 3;

  // Output vector order:
  // {pc_stall, pc_redirect, if_id_stall, if_id_flush, id_ex_stall,
  //  id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush, mdu_busy}
  localparam logic [9:0] EXP_IDLE     = 10'b0000000000;
  localparam logic [9:0] EXP_RESET    = 10'b0001010110;
  localparam logic [9:0] EXP_DMEM     = 10'b1010101010;
  localparam logic [9:0] EXP_DMEM_MDU = 10'b1010101011;
  localparam logic [9:0] EXP_MDU      = 10'b1010100101;
  localparam logic [9:0] EXP_REDIRECT = 10'b0101010000;
  localparam logic [9:0] EXP_LOADUSE  = 10'b1010010000;
  localparam logic [9:0] EXP_IMEM     = 10'b1001000000;

  typedef struct {
    logic [9:0]       outs;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;
    logic             perfValid;
    string            tag;
  } expEntry_t;

  logic clk;
  logic rst;

  expEntry_t        scoreboard[$];
  int               vectors;
  int               miscompares;
  logic [CNT_W-1:0] modelStall;
  logic [CNT_W-1:0] modelFlush;
  logic             perfKnown;

  cpu_pipe_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  cpu_pipe_ctrl #(
    .REG_AW  (REG_AW),
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a broken design can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle's worth of inputs
  task automatic drive(input logic r,
                       input logic [REG_AW-1:0] rs1, input logic u1,
                       input logic [REG_AW-1:0] rs2, input logic u2,
                       input logic [REG_AW-1:0] rd, input logic ld,
                       input logic redir, input logic mdu,
                       input logic imemRdy, input logic memAcc,
                       input logic dmemRdy);
    rst              = r;
    bus.id_rs1_addr  = rs1;
    bus.id_rs1_used  = u1;
    bus.id_rs2_addr  = rs2;
    bus.id_rs2_used  = u2;
    bus.ex_rd_addr   = rd;
    bus.ex_mem_read  = ld;
    bus.ex_redirect  = redir;
    bus.ex_mdu_start = mdu;
    bus.imem_ready   = imemRdy;
    bus.mem_access   = memAcc;
    bus.dmem_ready   = dmemRdy;
  endtask

  task automatic driveIdle(input logic r);
    drive(r, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  // Pop the oldest expectation and compare against what the DUT shows now
  task automatic checkOutput();
    expEntry_t  e;
    logic [9:0] obs;
    if (scoreboard.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = scoreboard.pop_front();
      obs = {bus.pc_stall, bus.pc_redirect, bus.if_id_stall, bus.if_id_flush,
             bus.id_ex_stall, bus.id_ex_flush, bus.ex_mem_stall,
             bus.ex_mem_flush, bus.mem_wb_flush, bus.mdu_busy};
      vectors++;
      assert (obs === e.outs) else begin
        miscompares++;
        $error("[TB] FAIL %s ctrl: observed %b expected %b", e.tag, obs, e.outs);
      end
      if (e.perfValid) begin
        vectors++;
        assert (bus.perf_stall_cnt === e.stallCnt) else begin
          miscompares++;
          $error("[TB] FAIL %s perf_stall_cnt: observed %0d expected %0d",
                 e.tag, bus.perf_stall_cnt, e.stallCnt);
        end
        vectors++;
        assert (bus.perf_flush_cnt === e.flushCnt) else begin
          miscompares++;
          $error("[TB] FAIL %s perf_flush_cnt: observed %0d expected %0d",
                 e.tag, bus.perf_flush_cnt, e.flushCnt);
        end
      end
    end
  endtask

  // Queue the expectation for the inputs just driven, check it mid-cycle,
  // then advance the perf model for the coming rising edge
  task automatic applyStimulus(input logic [9:0] expOuts, input string tag);
    expEntry_t e;
    e.outs      = expOuts;
    e.tag       = tag;
    e.perfValid = perfKnown;
`ifdef CPU_PIPE_PERF_EN
    e.stallCnt  = modelStall;
    e.flushCnt  = modelFlush;
`else
    e.stallCnt  = '0;
    e.flushCnt  = '0;
`endif
    scoreboard.push_back(e);
    @(negedge clk);
    checkOutput();
    if (rst) begin
      modelStall = '0;
      modelFlush = '0;
      perfKnown  = 1'b1;
    end else begin
      if (expOuts[9] && (modelStall != '1)) modelStall = modelStall + 1'b1;
      if (expOuts[8] && (modelFlush != '1)) modelFlush = modelFlush + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    modelStall  = '0;
    modelFlush  = '0;
    perfKnown   = 1'b0;

    // Reset
    driveIdle(1'b1); applyStimulus(EXP_RESET, "reset0");
    driveIdle(1'b1); applyStimulus(EXP_RESET, "reset1");
    driveIdle(1'b0); applyStimulus(EXP_IDLE,  "idle");

    // Load-use hazards
    drive(0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 1, 0, 1); applyStimulus(EXP_LOADUSE, "lu_rs1");
    driveIdle(1'b0);                                    applyStimulus(EXP_IDLE,    "lu_one_bubble");
    drive(0, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 1, 0, 1); applyStimulus(EXP_IDLE,    "lu_rd_x0");
    drive(0, 5'd7, 0, 5'd7, 1, 5'd7, 1, 0, 0, 1, 0, 1); applyStimulus(EXP_LOADUSE, "lu_rs2");
    drive(0, 5'd7, 0, 5'd7, 0, 5'd7, 1, 0, 0, 1, 0, 1); applyStimulus(EXP_IDLE,    "lu_srcs_unused");
    drive(0, 5'd9, 1, 5'd3, 1, 5'd9, 0, 0, 0, 1, 0, 1); applyStimulus(EXP_IDLE,    "no_load");

    // Imem wait and priority against load-use / redirect
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 1); applyStimulus(EXP_IMEM,     "imem_wait");
    drive(0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0, 1); applyStimulus(EXP_LOADUSE,  "lu_over_imem");
    drive(0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, 1); applyStimulus(EXP_REDIRECT, "br_over_lu");
    driveIdle(1'b0);                                    applyStimulus(EXP_IDLE,     "idle_after_br");

    // MDU, 4-cycle latency; a redirect while busy is held off
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 0, 1); applyStimulus(EXP_MDU,  "mdu_c1");
    driveIdle(1'b0);                                    applyStimulus(EXP_MDU,  "mdu_c2");
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1, 0, 1); applyStimulus(EXP_MDU,  "mdu_over_br");
    driveIdle(1'b0);                                    applyStimulus(EXP_MDU,  "mdu_c4");
    driveIdle(1'b0);                                    applyStimulus(EXP_IDLE, "mdu_done");

    // Dmem wait of 3 cycles with a pending redirect taken on release
    for (int i = 0; i < 3; i++) begin
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1, 1, 0);
      applyStimulus(EXP_DMEM, "dmem_hold_br");
    end
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1, 1, 1); applyStimulus(EXP_REDIRECT, "dmem_release_br");
    driveIdle(1'b0);                                    applyStimulus(EXP_IDLE,     "idle_after_dmem");

    // Dmem wait arriving mid-MDU with two cycles left; count is frozen
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 0, 1); applyStimulus(EXP_MDU,      "mdu2_start");
    driveIdle(1'b0);                                    applyStimulus(EXP_MDU,      "mdu2_c2");
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1, 0); applyStimulus(EXP_DMEM_MDU, "mdu2_dmem1");
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1, 0); applyStimulus(EXP_DMEM_MDU, "mdu2_dmem2");
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1, 1); applyStimulus(EXP_MDU,      "mdu2_release");
    driveIdle(1'b0);                                    applyStimulus(EXP_MDU,      "mdu2_rest1");
    driveIdle(1'b0);                                    applyStimulus(EXP_MDU,      "mdu2_rest2");
    driveIdle(1'b0);                                    applyStimulus(EXP_IDLE,     "mdu2_done");

    // Reset in the middle of an MDU op, with a dmem stall on the inputs
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 0, 1); applyStimulus(EXP_MDU,   "mdu3_start");
    driveIdle(1'b0);                                    applyStimulus(EXP_MDU,   "mdu3_c2");
    drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 1, 0); applyStimulus(EXP_RESET, "rst_mid_mdu");
    driveIdle(1'b0);                                    applyStimulus(EXP_IDLE,  "post_rst_run");

    // Perf counters climb from zero and saturate
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1, 0, 1); applyStimulus(EXP_REDIRECT, "perf_br");
    for (int i = 0; i < 9; i++) begin
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 1);
      applyStimulus(EXP_IMEM, "perf_imem");
    end
    driveIdle(1'b0); applyStimulus(EXP_IDLE, "perf_saturated");
    driveIdle(1'b0); applyStimulus(EXP_IDLE, "perf_hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_pipe_ctrl.md
Name: cpu_pipe_ctrl

Overview:
- Parametrised pipeline control unit for the 5-stage RV core (IF/ID/EX/MEM/WB); replaces the single-cycle controller.
- Generates per-stage stall/flush and PC redirect from load-use hazards, EX-stage branch/jump resolution, the multi-cycle MUL/DIV unit and imem/dmem wait handshakes.
- Sits beside the datapath. Its only state is a small FSM, the MDU latency counter and optional perf counters.

Parameters:
- REG_AW, 5, register address width (5 = RV32I, 4 = RV32E)
- MDU_LAT, 4, MUL/DIV result latency in cycles (>=2)
- CNT_W, 32, perf counter width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_rs1_addr  in  REG_AW  ID source reg 1
- id_rs2_addr  in  REG_AW  ID source reg 2
- id_rs1_used  in  1  ID instr reads rs1
- id_rs2_used  in  1  ID instr reads rs2
- ex_rd_addr  in  REG_AW  EX destination reg
- ex_mem_read  in  1  EX instr is a load
- ex_redirect  in  1  EX taken branch or jump
- ex_mdu_start  in  1  EX instr is MUL/DIV, first EX cycle
- imem_ready  in  1  fetch data valid this cycle
- mem_access  in  1  MEM instr accesses dmem
- dmem_ready  in  1  dmem access completes this cycle
- pc_stall  out  1  hold PC
- pc_redirect  out  1  load PC from EX target
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  bubble into IF/ID
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  bubble into ID/EX
- ex_mem_stall  out  1  hold EX/MEM
- ex_mem_flush  out  1  bubble into EX/MEM
- mem_wb_flush  out  1  bubble into MEM/WB
- mdu_busy  out  1  MDU operation in progress
- perf_stall_cnt  out  CNT_W  cycles with pc_stall=1
- perf_flush_cnt  out  CNT_W  redirect events

Behaviour:
- All control outputs are combinational from inputs and registered state. State updates on the rising clk edge.
- While rst=1:
  - All *_flush = 1; all stalls, pc_redirect and mdu_busy = 0.
  - Next cycle: FSM = RUN, mdu_cnt = 0, perf counters = 0.
  - Reset mid-MDU or mid-dmem wait abandons the operation.
- FSM states: RUN, MDU_WAIT, MEM_WAIT.
  - RUN -> MDU_WAIT: on ex_mdu_start, unless a dmem stall is active. mdu_cnt loads MDU_LAT-1.
  - MDU_WAIT: mdu_cnt decrements each cycle. At mdu_cnt==1 -> RUN. mdu_busy=1 while in MDU_WAIT or on the start cycle.
  - RUN/MDU_WAIT -> MEM_WAIT: when mem_access=1 and dmem_ready=0. Returns to the prior state on dmem_ready=1. mdu_cnt is frozen in MEM_WAIT.
- Priority, highest first:
  1. dmem stall (mem_access & ~dmem_ready): stall PC, IF/ID, ID/EX, EX/MEM; mem_wb_flush=1; redirect suppressed. ex_redirect stays asserted because EX is held, so it is taken on release.
  2. MDU busy: stall PC, IF/ID, ID/EX; ex_mem_flush=1.
  3. ex_redirect: pc_redirect=1, if_id_flush=1, id_ex_flush=1, no stalls. This overrides load-use and imem wait.
  4. Load-use (ex_mem_read & rd!=0 & ((rs1_used & rs1==rd) | (rs2_used & rs2==rd))): stall PC and IF/ID; id_ex_flush=1. Exactly 1 bubble.
  5. imem not ready: pc_stall=1, if_id_flush=1.
- rd==x0 never creates a hazard. Forwarding resolves all other RAW cases and is outside this block.
- Perf counters saturate at all-ones; they never wrap.

Optional Feature:
- Macro CPU_PIPE_PERF_EN.
- Defined: perf_stall_cnt increments every cycle with pc_stall=1 (rst low). perf_flush_cnt increments on every cycle with pc_redirect=1.
- Undefined: no counter flops; both ports tied to 0.

Decomposition:
- Shared header cpu_defs.vh holds FSM state encodings (RUN=2'd0, MDU_WAIT=2'd1, MEM_WAIT=2'd2) and the default REG_AW/MDU_LAT values.
- One natural sub-module: cpu_hazard_det, the combinational load-use comparator, parametrised by REG_AW, reused by the future dual-issue front end.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 used -> pc_stall=if_id_stall=id_ex_flush=1 for exactly 1 cycle. Same with ex_rd=0 -> no stall.
- MDU, MDU_LAT=4: ex_mdu_start pulse -> mdu_busy and pc_stall high 4 cycles, ex_mem_flush high the same 4 cycles, FSM back in RUN on cycle 5.
- Branch plus load-use the same cycle -> pc_redirect=1, if_id_flush=id_ex_flush=1, pc_stall=0. perf_flush_cnt +1 when CPU_PIPE_PERF_EN is defined.
- dmem wait 3 cycles with ex_redirect=1 -> stalls on EX/MEM and earlier, mem_wb_flush=1, pc_redirect=0 for 3 cycles, then pc_redirect=1 on the release cycle.
- dmem wait starting during MDU_WAIT (mdu_cnt=2) for 2 cycles -> mdu_cnt holds at 2, MDU finishes 2 cycles after release.
- rst asserted during MDU_WAIT -> all flushes=1 while rst is high. Next cycle: FSM=RUN, mdu_busy=0, perf counters=0.
